// File: rtl/sap_pkg.sv
// Shared SAP-1.5 definitions: memory geometry and the program-loader state encoding.
package sap_pkg;

  localparam int SAP_ADDR_WIDTH = 4;
  localparam int SAP_DATA_WIDTH = 8;
  localparam int SAP_RAM_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMMIT,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams bytes into consecutive RAM addresses from a base (with wrap-around) while
// holding the CPU in reset; releases the CPU once the final write has been committed.
module prog_loader
  import sap_pkg::*;
#(
  parameter int ADDR_WIDTH     = SAP_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SAP_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0] DEPTH        = LEN_W'(2 ** ADDR_WIDTH);
  localparam logic [CNT_W-1:0] IDLE_LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;

  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic accept;

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid && in_ready;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      idle_cnt_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      count_q     <= count_d;
      idle_cnt_q  <= idle_cnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // NOTE: every variable gets a hold default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    count_d    = count_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (length == '0) begin
            state_d = DONE;
          end else if (length > DEPTH) begin
            state_d = ERROR;
          end else begin
            len_d      = length;
            addr_d     = base_addr;
            count_d    = '0;
            idle_cnt_d = '0;
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          addr_d     = addr_q + ADDR_WIDTH'(1);
          count_d    = count_q + LEN_W'(1);
          idle_cnt_d = '0;
          if (count_d == len_q) state_d = COMMIT;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
          // The cycle that brings idle_cnt up to the limit is the one that times out.
          if (idle_cnt_q == IDLE_LIMIT_M1) state_d = ERROR;
        end
      end
      COMMIT:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    ram_we_d    = accept;
    ram_addr_d  = accept ? addr_q : ram_addr_q;
    ram_wdata_d = accept ? in_data : ram_wdata_q;
    cpu_reset_d = (state_d != DONE);
    busy_d      = (state_d == LOAD) || (state_d == COMMIT);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a vector table of complete loads plus hand-written
// timeout, reset-mid-load and reset-vs-start sequences against a bench-side RAM image.
module tb_prog_loader;
  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int checks   = 0;
  int failures = 0;

  // Bench-side RAM and write log, sampled mid-cycle on the falling edge.
  logic [7:0] mem [16];
  logic [3:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         cyc         = 0;
  int         last_we_cyc = -1;
  int         fall_cyc    = -1;
  logic       prev_cr     = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
      last_we_cyc <= cyc + 1;
    end
    if (prev_cr && !cpu_reset) fall_cyc <= cyc + 1;
    prev_cr <= cpu_reset;
  end

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         nbytes;
    int         gap;
    logic [7:0] data [4];
    int         exp_nw;
    logic [3:0] exp_addr [4];
    logic       exp_done;
    logic       exp_error;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [3:0] b, input logic [4:0] l,
                         input int nb, input int gap,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input int nw,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] a3,
                         input logic dn, input logic er, input int lat);
    vecs[i].base        = b;
    vecs[i].len         = l;
    vecs[i].nbytes      = nb;
    vecs[i].gap         = gap;
    vecs[i].data[0]     = d0;
    vecs[i].data[1]     = d1;
    vecs[i].data[2]     = d2;
    vecs[i].data[3]     = d3;
    vecs[i].exp_nw      = nw;
    vecs[i].exp_addr[0] = a0;
    vecs[i].exp_addr[1] = a1;
    vecs[i].exp_addr[2] = a2;
    vecs[i].exp_addr[3] = a3;
    vecs[i].exp_done    = dn;
    vecs[i].exp_error   = er;
    vecs[i].exp_lat     = lat;
  endtask

  task automatic start_load(input logic [3:0] b, input logic [4:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = d;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end(output int lat);
    lat = 0;
    while (!(done || error) && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    in_valid  = 1'b0;
    in_data   = '0;

    // base len nb gap  d0..d3                 nw  a0..a3           done err lat
    set_vec(0, 4'd0,  5'd2,  2, 0, 8'h1F, 8'hFF, 8'h00, 8'h00, 2, 4'd0,  4'd1,  4'd0, 4'd0, 1, 0, 1);
    set_vec(1, 4'd15, 5'd1,  1, 5, 8'hAB, 8'h00, 8'h00, 8'h00, 1, 4'd15, 4'd0,  4'd0, 4'd0, 1, 0, 1);
    set_vec(2, 4'd14, 5'd4,  4, 0, 8'h11, 8'h22, 8'h33, 8'h44, 4, 4'd14, 4'd15, 4'd0, 4'd1, 1, 0, 1);
    set_vec(3, 4'd5,  5'd17, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'd0,  4'd0,  4'd0, 4'd0, 0, 1, 0);
    set_vec(4, 4'd5,  5'd0,  0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'd0,  4'd0,  4'd0, 4'd0, 1, 0, 0);
    set_vec(5, 4'd7,  5'd3,  3, 2, 8'hC1, 8'hC2, 8'hC3, 8'h00, 3, 4'd7,  4'd8,  4'd9, 4'd0, 1, 0, 1);

    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_ram_we",    32'(ram_we),    32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      wr_addr.delete();
      wr_data.delete();
      start_load(vecs[i].base, vecs[i].len);
      if (vecs[i].nbytes > 0) begin
        check($sformatf("v%0d_load_busy", i),      32'(busy),      32'd1);
        check($sformatf("v%0d_load_ready", i),     32'(in_ready),  32'd1);
        check($sformatf("v%0d_load_cpu_reset", i), 32'(cpu_reset), 32'd1);
      end
      for (int j = 0; j < vecs[i].nbytes; j++)
        send_byte(vecs[i].data[j], (j == 0) ? vecs[i].gap : 0);
      wait_end(lat);
      check($sformatf("v%0d_latency", i),   32'(lat),       32'(vecs[i].exp_lat));
      check($sformatf("v%0d_done", i),      32'(done),      32'(vecs[i].exp_done));
      check($sformatf("v%0d_error", i),     32'(error),     32'(vecs[i].exp_error));
      check($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset), 32'(!vecs[i].exp_done));
      check($sformatf("v%0d_busy", i),      32'(busy),      32'd0);
      check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'd0);
      tick();
      check($sformatf("v%0d_nwrites", i), 32'(wr_addr.size()), 32'(vecs[i].exp_nw));
      for (int j = 0; j < vecs[i].exp_nw; j++) begin
        if (j < wr_addr.size()) begin
          check($sformatf("v%0d_w%0d_addr", i, j), 32'(wr_addr[j]), 32'(vecs[i].exp_addr[j]));
          check($sformatf("v%0d_w%0d_data", i, j), 32'(wr_data[j]), 32'(vecs[i].data[j]));
        end
      end
      if (vecs[i].exp_done && vecs[i].exp_nw > 0)
        check($sformatf("v%0d_cpu_release_delay", i), 32'(fall_cyc - last_we_cyc), 32'd1);
    end

    // Timeout: one byte then silence until ERROR.
    wr_addr.delete();
    wr_data.delete();
    start_load(4'd2, 5'd3);
    send_byte(8'h5A, 0);
    n = 0;
    while (!error && n < 300) begin
      tick();
      n++;
    end
    check("to_cycles",    32'(n),         32'd255);
    check("to_error",     32'(error),     32'd1);
    check("to_cpu_reset", 32'(cpu_reset), 32'd1);
    check("to_busy",      32'(busy),      32'd0);
    tick();
    check("to_nwrites",   32'(wr_addr.size()), 32'd1);
    check("to_mem2",      32'(mem[2]),    32'h5A);

    // Recovery from ERROR with a normal one-byte load.
    wr_addr.delete();
    wr_data.delete();
    start_load(4'd9, 5'd1);
    check("rec_error_cleared", 32'(error), 32'd0);
    send_byte(8'h77, 0);
    wait_end(lat);
    check("rec_done",      32'(done),      32'd1);
    check("rec_cpu_reset", 32'(cpu_reset), 32'd0);
    tick();
    check("rec_nwrites",   32'(wr_addr.size()), 32'd1);
    check("rec_mem9",      32'(mem[9]),    32'h77);

    // Reset after two of four bytes.
    wr_addr.delete();
    wr_data.delete();
    start_load(4'd4, 5'd4);
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    reset = 1'b1;
    tick();
    check("mid_in_ready",  32'(in_ready),  32'd0);
    check("mid_ram_we",    32'(ram_we),    32'd0);
    check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_busy",      32'(busy),      32'd0);
    check("mid_nwrites",   32'(wr_addr.size()), 32'd2);
    check("mid_mem4",      32'(mem[4]),    32'hA1);
    check("mid_mem5",      32'(mem[5]),    32'hA2);

    // Reset and start together: reset wins.
    base_addr = 4'd0;
    length    = 5'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("rs_in_ready",  32'(in_ready),  32'd0);
    check("rs_busy",      32'(busy),      32'd0);
    check("rs_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rs_done",      32'(done),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
